gate_bist: RTL and testbench
============================

# gate_bist

Synthesizable exhaustive stimulus generator and response checker for small combinational gate modules. It drives every input pattern onto the gate under test, waits a programmable settle time, and samples the gate output. Each sample is compared against an expected truth table. It sits beside intro gate modules on the FPGA board as their in-hardware test partner and reports pass/fail, error count and first failing pattern.

## Interface
- `N_IN`, default 2: number of gate inputs; pattern space is 2^N_IN.
- `EXP_TT`, default 4'b1000 (AND): expected truth table, width 2^N_IN; bit i = expected f for pattern i.
- `SETTLE`, default 1: extra wait cycles per pattern before sampling, 0..15.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. This is a single clock domain.
- `start` in 1: single-cycle request to begin a run.
- `abort` in 1: cancels a running test.
- `f_in` in 1: output of gate under test.
- `x_out` out N_IN: stimulus pattern to gate inputs; bit 0 = first input.
- `busy` out 1: run in progress.
- `done` out 1: run completed; held until next start.
- `pass` out 1: valid while done; 1 iff err_cnt == 0.
- `err_cnt` out N_IN+1: number of mismatching patterns.
- `fail_valid` out 1: at least one mismatch recorded.
- `fail_idx` out N_IN: index of first mismatching pattern.

## Operation
- Reset values: every output is 0, and the state is IDLE.
- States are IDLE, RUN and DONE.
- IDLE:
  - x_out = 0.
  - start=1 → RUN next edge: idx=0, settle_cnt=0, err_cnt=0, fail_valid=0, fail_idx=0, busy=1.
- RUN:
  - x_out = idx.
  - settle_cnt increments each cycle.
  - On the cycle with settle_cnt == SETTLE, f_in is compared with EXP_TT[idx]:
    - Mismatch → err_cnt+1. If fail_valid=0, then fail_idx=idx and fail_valid=1.
    - idx == 2^N_IN−1 → DONE, busy=0, done=1, x_out=0.
    - Otherwise idx+1 and settle_cnt=0.
- DONE:
  - Outputs are held.
  - start=1 → clear done/pass/err_cnt/fail_*, enter RUN as from IDLE.
- abort=1 in RUN → IDLE next edge: busy=0, done=0, x_out=0. err_cnt/fail_* keep their partial values until the next start.
- Simultaneous events:
  - start and abort in the same cycle: abort wins in RUN. In IDLE or DONE, start wins.
  - start in RUN is ignored.
- err_cnt width N_IN+1 holds the maximum 2^N_IN without wrap, so no saturation logic is needed.
- pass = done & (err_cnt == 0). It is combinational from registers and never 1 outside DONE.
- rst_n low at any time: immediate return to reset values, with no partial result retained.

## Timing
- Each pattern window is SETTLE+1 cycles. A full run is 2^N_IN·(SETTLE+1) cycles from the first RUN cycle.
- start sampled at edge k → busy=1 and x_out=0 visible after edge k.
- f_in is sampled at the last edge of each window. The gate path must settle within SETTLE+1 cycles of an x_out change.
- done rises at the same edge as the final comparison, and busy falls at that edge.
- Example with N_IN=2, SETTLE=1: start at edge 0, done=1 after edge 8.
- All outputs are registered except pass.

## Structure
- Package `gate_bist_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - truth-table constants for N_IN=2: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001.
- Single module: the FSM, idx counter, settle counter and result registers stay together.
- No sub-module is needed.
- Board top wires x_out/f_in to the gate instance and maps done/pass to LEDs.

## Test plan
- AND gate, EXP_TT=TT_AND, SETTLE=1; start pulse → x_out sequence 0,0,1,1,2,2,3,3. Result: done=1 after 8 cycles, pass=1, err_cnt=0, fail_valid=0.
- OR gate with EXP_TT=TT_AND → err_cnt=2, fail_idx=1, fail_valid=1, pass=0.
- abort on cycle 3 of a run → IDLE next edge, busy=0, done=0, x_out=0. A new start then runs a full pass with err_cnt cleared.
- start pulses during RUN, and start+abort together in RUN → ignored / aborted respectively. The run length is unaffected by the ignored start.
- rst_n low mid-run (async, between edges) → all outputs 0 immediately. After release, state is IDLE with no done.
- SETTLE=0, XOR gate, EXP_TT=TT_XOR → done after 4 cycles, pass=1. A restart from DONE gives an identical second result.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg
// Shared types and constants for the gate BIST block.
//   state_t  : controller states (IDLE, RUN, DONE)
//   TT_*     : expected truth tables for 2-input gates, bit i = f(pattern i)
//   SETTLE_W : width of the per-pattern settle counter (SETTLE range 0..15)
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  localparam int SETTLE_W = 4;

endpackage

// File: rtl/gate_bist_if.sv
// gate_bist_if
// Bundles the control, stimulus and result signals of gate_bist.
//   start, abort : run control from the requester
//   f_in         : output of the gate under test
//   x_out        : stimulus pattern to the gate inputs (bit 0 = first input)
//   busy, done, pass, err_cnt, fail_valid, fail_idx : run status / result
// modport slave  : the BIST engine side
// modport master : the requester / gate side
interface gate_bist_if #(
  parameter int N_IN = 2
);

  logic            start;
  logic            abort;
  logic            f_in;
  logic [N_IN-1:0] x_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic            fail_valid;
  logic [N_IN-1:0] fail_idx;

  modport slave (
    input  start, abort, f_in,
    output x_out, busy, done, pass, err_cnt, fail_valid, fail_idx
  );

  modport master (
    output start, abort, f_in,
    input  x_out, busy, done, pass, err_cnt, fail_valid, fail_idx
  );

endinterface

// File: rtl/gate_bist.sv
// gate_bist
// Exhaustive stimulus generator and response checker for a small
// combinational gate. Walks every input pattern, waits SETTLE extra cycles,
// samples f_in on the last cycle of each window and compares it against
// EXP_TT. Reports error count, first failing pattern and pass/fail.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gate_bist_if slave (start/abort/f_in in, stimulus and results out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; x_out = 0
// RUN   | driving x_out = idx, counting settle cycles, comparing f_in
// DONE  | run finished; results held until the next start
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int                 N_IN   = 2,
  parameter logic [2**N_IN-1:0] EXP_TT = TT_AND,
  parameter int                 SETTLE = 1
) (
  input logic       clk,
  input logic       rst_n,
  gate_bist_if.slave bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_C = SETTLE_W'(SETTLE);

  state_t              r_state, w_state_nxt;
  logic [N_IN-1:0]     r_idx, w_idx_nxt;
  logic [N_IN-1:0]     r_x_out, w_x_out_nxt;
  logic [N_IN-1:0]     r_fail_idx, w_fail_idx_nxt;
  logic [SETTLE_W-1:0] r_settle, w_settle_nxt;
  logic [N_IN:0]       r_err_cnt, w_err_cnt_nxt;
  logic                r_fail_valid, w_fail_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;

  logic w_run;
  logic w_go;
  logic w_abort;
  logic w_sample;
  logic w_last;
  logic w_mismatch;

  assign w_run      = (r_state == RUN);
  // start is ignored while running; abort only matters while running
  assign w_go       = bus.start && !w_run;
  assign w_abort    = bus.abort && w_run;
  assign w_sample   = w_run && (r_settle == SETTLE_C);
  assign w_last     = &r_idx;
  assign w_mismatch = (bus.f_in != EXP_TT[r_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_x_out      <= '0;
      r_fail_idx   <= '0;
      r_settle     <= '0;
      r_err_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_x_out      <= w_x_out_nxt;
      r_fail_idx   <= w_fail_idx_nxt;
      r_settle     <= w_settle_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_fail_valid <= w_fail_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (bus.start) w_state_nxt = RUN;
      RUN: begin
        if (bus.abort)             w_state_nxt = IDLE;
        else if (w_sample && w_last) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters. x_out is registered
  // alongside idx so that every output except pass comes straight from a flop.
  always_comb begin
    w_idx_nxt        = r_idx;
    w_x_out_nxt      = r_x_out;
    w_fail_idx_nxt   = r_fail_idx;
    w_settle_nxt     = r_settle;
    w_err_cnt_nxt    = r_err_cnt;
    w_fail_valid_nxt = r_fail_valid;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;

    if (w_go) begin
      w_idx_nxt        = '0;
      w_x_out_nxt      = '0;
      w_fail_idx_nxt   = '0;
      w_settle_nxt     = '0;
      w_err_cnt_nxt    = '0;
      w_fail_valid_nxt = 1'b0;
      w_busy_nxt       = 1'b1;
      w_done_nxt       = 1'b0;
    end else if (w_abort) begin
      // partial err_cnt / fail_* stay visible until the next start
      w_x_out_nxt = '0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
    end else if (w_run) begin
      if (w_sample) begin
        if (w_mismatch) begin
          w_err_cnt_nxt = r_err_cnt + (N_IN+1)'(1);
          if (!r_fail_valid) begin
            w_fail_idx_nxt   = r_idx;
            w_fail_valid_nxt = 1'b1;
          end
        end
        if (w_last) begin
          w_x_out_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt    = r_idx + N_IN'(1);
          w_x_out_nxt  = r_idx + N_IN'(1);
          w_settle_nxt = '0;
        end
      end else begin
        w_settle_nxt = r_settle + SETTLE_W'(1);
      end
    end
  end

  assign bus.x_out      = r_x_out;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.fail_valid = r_fail_valid;
  assign bus.fail_idx   = r_fail_idx;
  assign bus.pass       = r_done && (r_err_cnt == '0);

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist
// Directed bench for gate_bist. Two instances: dut1 (AND table, SETTLE=1)
// and dut0 (XOR table, SETTLE=0). A behavioural gate per instance drives
// f_in from x_out through a selectable truth table. Status is compared as
// a packed vector {busy, done, pass, fail_valid, err_cnt, fail_idx, x_out}.
module tb_gate_bist;
  import gate_bist_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] gate_tt1;
  logic [3:0] gate_tt0;
  int         checks;
  int         errors;

  gate_bist_if #(.N_IN(2)) bus1 ();
  gate_bist_if #(.N_IN(2)) bus0 ();

  assign bus1.f_in = gate_tt1[bus1.x_out];
  assign bus0.f_in = gate_tt0[bus0.x_out];

  gate_bist #(.N_IN(2), .EXP_TT(TT_AND), .SETTLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  gate_bist #(.N_IN(2), .EXP_TT(TT_XOR), .SETTLE(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  logic [10:0] st1, st0;
  assign st1 = {bus1.busy, bus1.done, bus1.pass, bus1.fail_valid,
                bus1.err_cnt, bus1.fail_idx, bus1.x_out};
  assign st0 = {bus0.busy, bus0.done, bus0.pass, bus0.fail_valid,
                bus0.err_cnt, bus0.fail_idx, bus0.x_out};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    rst_n = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    gate_tt1 = TT_AND;
    gate_tt0 = TT_XOR;
    #12;
    exp = '0;
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL reset_dut1: got %b expected %b", st1, exp);
    end
    checks++;
    if (st0 !== exp) begin
      errors++; $display("FAIL reset_dut0: got %b expected %b", st0, exp);
    end
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL idle_after_reset: got %b expected %b", st1, exp);
    end
  endtask

  task automatic test_and_pass();
    logic [10:0] exp;
    gate_tt1 = TT_AND;
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'(j / 2)};
      checks++;
      if (st1 !== exp) begin
        errors++; $display("FAIL and_seq[%0d]: got %b expected %b", j, st1, exp);
      end
      if (j < 7) tick();
    end
    tick();
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0};
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL and_done: got %b expected %b", st1, exp);
    end
    tick(); tick();
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL and_done_hold: got %b expected %b", st1, exp);
    end
  endtask

  task automatic test_or_mismatch();
    logic [10:0] exp;
    int n;
    gate_tt1 = TT_OR;
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0};
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL or_restart_clear: got %b expected %b", st1, exp);
    end
    n = 0;
    while (bus1.done !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 8) begin
      errors++; $display("FAIL or_run_len: got %0d expected 8", n);
    end
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 2'd1, 2'd0};
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL or_result: got %b expected %b", st1, exp);
    end
  endtask

  task automatic test_abort();
    logic [10:0] exp;
    int n;
    gate_tt1 = TT_AND;
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    tick(); tick();
    bus1.abort = 1'b1; tick(); bus1.abort = 1'b0;
    exp = '0;
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL abort_idle: got %b expected %b", st1, exp);
    end
    tick(); tick();
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL abort_stays_idle: got %b expected %b", st1, exp);
    end
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    n = 0;
    while (bus1.done !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 8) begin
      errors++; $display("FAIL abort_rerun_len: got %0d expected 8", n);
    end
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0};
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL abort_rerun_result: got %b expected %b", st1, exp);
    end
  endtask

  task automatic test_start_abort_mix();
    logic [10:0] exp;
    int n;
    gate_tt1 = TT_AND;
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    tick(); tick();
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    n = 3;
    while (bus1.done !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 8) begin
      errors++; $display("FAIL start_in_run_len: got %0d expected 8", n);
    end
    // start+abort while running: abort wins, partial results stay
    gate_tt1 = TT_OR;
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    tick(); tick(); tick(); tick();
    bus1.start = 1'b1; bus1.abort = 1'b1; tick();
    bus1.start = 1'b0; bus1.abort = 1'b0;
    exp = {1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 2'd1, 2'd0};
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL start_abort_run: got %b expected %b", st1, exp);
    end
    // start+abort from IDLE: start wins
    bus1.start = 1'b1; bus1.abort = 1'b1; tick();
    bus1.start = 1'b0; bus1.abort = 1'b0;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0};
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL start_abort_idle: got %b expected %b", st1, exp);
    end
    n = 0;
    while (bus1.done !== 1'b1 && n < 20) begin tick(); n++; end
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 2'd1, 2'd0};
    checks++;
    if (n !== 8 || st1 !== exp) begin
      errors++; $display("FAIL start_abort_idle_run: got len %0d st %b expected len 8 st %b", n, st1, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] exp;
    gate_tt1 = TT_OR;
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    repeat (6) tick();
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 2'd1, 2'd3};
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL pre_reset_partial: got %b expected %b", st1, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    exp = '0;
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL async_reset: got %b expected %b", st1, exp);
    end
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (st1 !== exp) begin
      errors++; $display("FAIL after_reset_idle: got %b expected %b", st1, exp);
    end
  endtask

  task automatic test_xor_settle0();
    logic [10:0] exp;
    logic [10:0] first;
    int n;
    gate_tt0 = TT_XOR;
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'(j)};
      checks++;
      if (st0 !== exp) begin
        errors++; $display("FAIL xor_seq[%0d]: got %b expected %b", j, st0, exp);
      end
      if (j < 3) tick();
    end
    tick();
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0};
    first = st0;
    checks++;
    if (st0 !== exp) begin
      errors++; $display("FAIL xor_done: got %b expected %b", st0, exp);
    end
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    n = 0;
    while (bus0.done !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL xor_rerun_len: got %0d expected 4", n);
    end
    checks++;
    if (st0 !== exp) begin
      errors++; $display("FAIL xor_rerun_result: got %b expected %b (first %b)", st0, exp, first);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_and_pass();
    test_or_mismatch();
    test_abort();
    test_start_abort_mix();
    test_reset_mid();
    test_xor_settle0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
